// File: rtl/safe_pkg.sv
// Shared types and widths for the combination safe.
// Holds the FSM state enum and the counter widths.
package safe_pkg;

  localparam int FAIL_W = 4;
  localparam int LOCK_W = 16;

  typedef enum logic [2:0] {
    S0     = 3'd0,
    S1     = 3'd1,
    S2     = 3'd2,
    S3     = 3'd3,
    OPEN   = 3'd4,
    LOCKED = 3'd5
  } safe_state_e;

endpackage

// File: rtl/safe_lockout_timer.sv
// Lockout down-counter: start loads the cycle count,
// done flags the final cycle. Ports: clk, reset(n), start, load, done.
module safe_lockout_timer
  import safe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LOCK_W-1:0] load,
  output logic              done
);

  logic [LOCK_W-1:0] cnt_q;
  logic [LOCK_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count equals 1 in the last locked cycle, so
  // the FSM leaves after exactly 'load' cycles.
  assign done = (cnt_q == LOCK_W'(1));

endmodule

// File: rtl/safe.sv
// Combination safe: four bytes MSB first open it, repeated
// failures lock it out. Ports: clk, reset(n), din, din_valid, unlocked.
module safe
  import safe_pkg::*;
#(
  parameter logic [31:0] CODE           = 32'hBAADC0DE,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       unlocked
);

  localparam logic [7:0] FIRST =
    CODE[31:24];
  localparam logic [FAIL_W-1:0] MAX_CNT =
    FAIL_W'(MAX_FAILS);
  localparam logic [LOCK_W-1:0] LOCK_LOAD =
    LOCK_W'(LOCKOUT_CYCLES);

  safe_state_e       state_q, state_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [FAIL_W-1:0] fail_inc;
  logic              unlocked_q, unlocked_d;
  logic [7:0]        exp_byte;
  logic              lock_start;
  logic              lock_done;

  safe_lockout_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .start (lock_start),
    .load  (LOCK_LOAD),
    .done  (lock_done)
  );

  always_comb begin
    exp_byte = CODE[31:24];
    case (state_q)
      S1:      exp_byte = CODE[23:16];
      S2:      exp_byte = CODE[15:8];
      S3:      exp_byte = CODE[7:0];
      default: exp_byte = CODE[31:24];
    endcase
  end

  always_comb begin
    fail_inc = fail_q;
    if (fail_q != '1) begin
      fail_inc = fail_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    lock_start = 1'b0;
    case (state_q)
      S0, S1, S2, S3: begin
        if (din_valid) begin
          if (din == exp_byte) begin
            case (state_q)
              S0:      state_d = S1;
              S1:      state_d = S2;
              S2:      state_d = S3;
              default: begin
                state_d = OPEN;
                fail_d  = '0;
              end
            endcase
          end else if (fail_inc == MAX_CNT) begin
            state_d    = LOCKED;
            fail_d     = '0;
            lock_start = 1'b1;
          end else begin
            fail_d = fail_inc;
            // A wrong byte may itself start a new attempt.
            state_d = (din == FIRST) ? S1 : S0;
          end
        end
      end
      LOCKED: begin
        if (lock_done) begin
          state_d = S0;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
    unlocked_d = (state_d == OPEN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S0;
      fail_q     <= '0;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
    end
  end

  assign unlocked = unlocked_q;

endmodule

// File: tb/tb_safe.sv
// Bench for the safe: vector table and hand sequences,
// expected unlocked values queued and checked after each edge.
module tb_safe;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       unlocked;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       rst_n;
    logic       vld;
    logic [7:0] d;
    logic       exp;
    string      name;
  } vec_t;

  typedef struct {
    logic  exp;
    string name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  safe dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .unlocked  (unlocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic       r,
    input logic       v,
    input logic [7:0] d,
    input logic       e,
    input string      nm
  );
    sb_t s;
    sb_t got;
    reset     = r;
    din_valid = v;
    din       = d;
    s.exp     = e;
    s.name    = nm;
    sb.push_back(s);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    n_tests++;
    if (unlocked !== got.exp) begin
      n_fail++;
      $display("FAIL %s: unlocked=%b expected=%b",
               got.name, unlocked, got.exp);
    end
  endtask

  task automatic add(
    input logic       r,
    input logic       v,
    input logic [7:0] d,
    input logic       e,
    input string      nm
  );
    vec_t x;
    x.rst_n = r;
    x.vld   = v;
    x.d     = d;
    x.exp   = e;
    x.name  = nm;
    tbl.push_back(x);
  endtask

  task automatic code(input logic e, input string nm);
    step(1, 1, 8'hBA, 0, nm);
    step(1, 1, 8'hAD, 0, nm);
    step(1, 1, 8'hC0, 0, nm);
    step(1, 1, 8'hDE, e, nm);
  endtask

  task automatic lock_it();
    step(0, 0, 8'h00, 0, "lk_rst");
    step(1, 1, 8'h00, 0, "lk_f1");
    step(1, 1, 8'h11, 0, "lk_f2");
    step(1, 1, 8'h22, 0, "lk_f3");
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;

    // reset state, X din during reset
    add(0, 0, 8'hxx, 0, "rst0");
    add(0, 1, 8'hBA, 0, "rst_prio");
    // straight code, then garbage
    add(1, 1, 8'hBA, 0, "s28_b0");
    add(1, 1, 8'hAD, 0, "s28_b1");
    add(1, 1, 8'hC0, 0, "s28_b2");
    add(1, 1, 8'hDE, 1, "s28_open");
    add(1, 1, 8'h55, 1, "s28_junk1");
    add(1, 1, 8'hBA, 1, "s28_junk2");
    add(1, 0, 8'hxx, 1, "s28_idle");
    // reset out of OPEN
    add(0, 1, 8'hDE, 0, "s33_rst");
    // gaps between bytes
    add(1, 1, 8'hBA, 0, "s29_b0");
    for (int i = 0; i < 5; i++)
      add(1, 0, 8'hxx, 0, "s29_gap");
    add(1, 1, 8'hAD, 0, "s29_b1");
    add(1, 0, 8'hC0, 0, "s29_gap2");
    add(1, 1, 8'hC0, 0, "s29_b2");
    add(1, 1, 8'hDE, 1, "s29_open");
    // reset mid-sequence
    add(0, 0, 8'h00, 0, "s32_rst0");
    add(1, 1, 8'hBA, 0, "s32_b0");
    add(1, 1, 8'hAD, 0, "s32_b1");
    add(1, 1, 8'hC0, 0, "s32_b2");
    add(0, 0, 8'h00, 0, "s32_rst");
    add(1, 1, 8'hDE, 0, "s32_de");
    add(1, 1, 8'hBA, 0, "s32_r0");
    add(1, 1, 8'hAD, 0, "s32_r1");
    add(1, 1, 8'hC0, 0, "s32_r2");
    add(1, 1, 8'hDE, 1, "s32_open");
    // two fails stay below the lockout limit
    add(0, 0, 8'h00, 0, "mf_rst");
    add(1, 1, 8'h00, 0, "mf_f1");
    add(1, 1, 8'h11, 0, "mf_f2");
    add(1, 1, 8'hBA, 0, "mf_b0");
    add(1, 1, 8'hAD, 0, "mf_b1");
    add(1, 1, 8'hC0, 0, "mf_b2");
    add(1, 1, 8'hDE, 1, "mf_open");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst_n, tbl[i].vld, tbl[i].d,
           tbl[i].exp, tbl[i].name);

    // overlapping restart on BA
    step(0, 0, 8'h00, 0, "s30_rst");
    step(1, 1, 8'hBA, 0, "s30_b0");
    step(1, 1, 8'hAD, 0, "s30_b1");
    step(1, 1, 8'hBA, 0, "s30_re");
    step(1, 1, 8'hAD, 0, "s30_b1b");
    step(1, 1, 8'hC0, 0, "s30_b2");
    step(1, 1, 8'hDE, 1, "s30_open");
    n_tests++;
    if (dut.fail_q !== 4'd0) begin
      n_fail++;
      $display("FAIL s30_fails: fail_q=%0d expected=0",
               dut.fail_q);
    end

    // lockout: code inside the window is ignored,
    // the edge of the window is exact
    lock_it();
    code(0, "s31_in_lock");
    for (int i = 5; i <= 15; i++)
      step(1, 0, 8'h00, 0, "s31_wait");
    step(1, 1, 8'hBA, 0, "s31_c16");
    step(1, 1, 8'hAD, 0, "s31_c17");
    step(1, 1, 8'hC0, 0, "s31_c18");
    step(1, 1, 8'hDE, 0, "s31_c19");

    // after a full lockout the code opens
    lock_it();
    for (int i = 1; i <= 16; i++)
      step(1, 1, 8'h77, 0, "s31_locked");
    code(1, "s31_after");

    // reset from LOCKED clears it at once
    lock_it();
    step(0, 0, 8'h00, 0, "lk_rst2");
    code(1, "lk_rst_open");
    step(0, 1, 8'hBA, 0, "s33_rst2");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/safe.md
SAFE -- requirements
Module: safe

Interface
REQ-001 Parameter CODE, default 32'hBAADC0DE, unlock combination; bytes are entered most significant byte first.
REQ-002 Parameter MAX_FAILS, default 3, number of consecutive failed attempts that triggers lockout; legal range 1..15.
REQ-003 Parameter LOCKOUT_CYCLES, default 16, number of clock cycles the lockout lasts; legal range 1..65535.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-006 Port din, input, 8 bits: entered combination byte.
REQ-007 Port din_valid, input, 1 bit: din is valid this cycle; each high cycle consumes exactly one byte; there is no backpressure.
REQ-008 Port unlocked, output, 1 bit, registered: the safe is open.

Function
REQ-009 The FSM SHALL have the states S0, S1, S2, S3, OPEN and LOCKED; Sn means n correct bytes have been accepted.
REQ-010 Byte k (k = 0..3) is expected to equal CODE[31-8k -: 8].
REQ-011 In Sn (n < 4), a cycle with din_valid=1 and the expected byte SHALL advance the FSM: S0->S1, S1->S2, S2->S3, S3->OPEN.
REQ-012 A cycle with din_valid=0 SHALL leave the state unchanged, so gaps between bytes are allowed and there is no timeout.
REQ-013 A wrong byte in any Sn SHALL count as one failed attempt.
REQ-014 On a wrong byte, the FSM SHALL go to S1 if din equals CODE[31:24], otherwise to S0; this allows overlapping restart.
REQ-015 The fail counter SHALL be 4 bits wide, SHALL saturate, and SHALL clear on entry to OPEN.
REQ-016 When a failed attempt brings the fail count to MAX_FAILS, the FSM SHALL enter LOCKED instead of S0/S1, and the fail counter SHALL clear.
REQ-017 LOCKED SHALL ignore din and din_valid for exactly LOCKOUT_CYCLES cycles, using a 16-bit down-counter, and then return to S0.
REQ-018 unlocked SHALL be 1 exactly while the state is OPEN; it rises on the rising edge of clk that accepts the fourth correct byte, so the latency is 1 cycle after that byte is sampled.
REQ-019 OPEN SHALL be sticky: din and din_valid are ignored there, and only reset leaves OPEN.
REQ-020 din is don't-care whenever din_valid=0; no X may propagate into the state.

Reset
REQ-021 While reset=0 at a rising edge of clk, the block SHALL load the state S0, fail counter 0, lockout counter 0 and unlocked 0.
REQ-022 Reset SHALL take priority over din_valid in the same cycle.
REQ-023 Reset asserted mid-sequence, in LOCKED, or in OPEN SHALL abort to S0 with the fail history cleared.
REQ-024 The first byte SHALL be accepted in the first cycle after reset returns to 1.

Structure
REQ-025 A package safe_pkg SHALL hold the state enum (safe_state_e) and the counter width constants FAIL_W=4 and LOCK_W=16.
REQ-026 The lockout timer SHALL be one sub-module, safe_lockout_timer, with inputs start and load value and output done.
REQ-027 The expected-byte select SHALL be combinational and indexed by the state.

Verification
REQ-028 Scenario: release reset, then drive BA, AD, C0, DE on 4 consecutive valid cycles. Required response: unlocked=1 from the next cycle on, and it stays 1 while garbage bytes are driven.
REQ-029 Scenario: drive BA, idle 5 cycles, then AD, idle, C0, DE. Required response: unlocked=1 (gaps tolerated).
REQ-030 Scenario: drive BA, AD, BA, AD, C0, DE. Required response: unlocked=1 after the last byte (restart on BA), with the fail count at 0 after the unlock.
REQ-031 Scenario: drive 3 wrong first bytes (00, 11, 22), then the correct code within 16 cycles. Required response: unlocked stays 0; the correct code entered after the lockout expires unlocks.
REQ-032 Scenario: drive BA, AD, C0, hold reset=0 for 1 cycle, then DE. Required response: unlocked stays 0; the full code entered afterwards unlocks.
REQ-033 Scenario: unlock, then reset=0 for 1 cycle. Required response: unlocked=0 in the next cycle.
